// File: rtl/pong_match_sequencer.sv
// Match-flow controller for two-player LED-matrix pong.
// Sequences ball reload / serve hold / rally / post-point pause / match end,
// keeps both scores and drives a combined decimal-weighted display value.
module pong_match_sequencer #(
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned PAUSE_TICKS = 8
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        tick,
  input  logic        serve_btn,
  input  logic        miss_p1,
  input  logic        miss_p2,
  output logic        ball_load,
  output logic        ball_run,
  output logic        serve_side,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic [13:0] disp_value,
  output logic        match_over,
  output logic        winner,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    RALLY = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
  localparam logic [7:0] PAUSE_END = 8'(PAUSE_TICKS - 1);

  state_t      state_q, state_d;
  logic        s1, s2, s3;
  logic        serve_edge;
  logic [7:0]  pause_cnt, pause_cnt_d;
  logic        pause_done;
  logic        win_reached;

  logic        ball_load_d, ball_run_d, serve_side_d, match_over_d, winner_d;
  logic [3:0]  score_p1_d, score_p2_d;
  logic [13:0] disp_value_d;
  logic [13:0] p1_wide, p2_wide;

  assign serve_edge  = s2 & ~s3;
  assign pause_done  = tick && (pause_cnt == PAUSE_END);
  assign win_reached = (score_p1 == WIN_VAL) || (score_p2 == WIN_VAL);
  assign state       = state_q;
  assign p1_wide     = {10'd0, score_p1};
  assign p2_wide     = {10'd0, score_p2};

  // Serve button synchronizer plus delay flop for rising-edge detection
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= serve_btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = LOAD;
      LOAD:  state_d = READY;
      READY: if (serve_edge) state_d = RALLY;
      RALLY: if (miss_p1 || miss_p2) state_d = POINT;
      POINT: if (pause_done) state_d = win_reached ? OVER : LOAD;
      OVER:  if (serve_edge) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from current and next state
  always_comb begin
    ball_load_d  = (state_d == LOAD);
    ball_run_d   = (state_d == RALLY);
    match_over_d = (state_d == OVER);
    serve_side_d = serve_side;
    winner_d     = winner;
    score_p1_d   = score_p1;
    score_p2_d   = score_p2;
    pause_cnt_d  = '0;
    disp_value_d = (p1_wide << 6) + (p1_wide << 5) + (p1_wide << 2) + p2_wide;
    case (state_q)
      RALLY: begin
        if (miss_p1 && !miss_p2) begin
          score_p2_d   = score_p2 + 4'd1;
          serve_side_d = 1'b0;
        end else if (miss_p2 && !miss_p1) begin
          score_p1_d   = score_p1 + 4'd1;
          serve_side_d = 1'b1;
        end
      end
      POINT: begin
        pause_cnt_d = tick ? pause_cnt + 8'd1 : pause_cnt;
        if (state_d == OVER) winner_d = (score_p2 == WIN_VAL);
      end
      OVER: begin
        if (serve_edge) begin
          score_p1_d   = '0;
          score_p2_d   = '0;
          serve_side_d = ~winner;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ball_load  <= 1'b0;
      ball_run   <= 1'b0;
      serve_side <= 1'b0;
      score_p1   <= '0;
      score_p2   <= '0;
      disp_value <= '0;
      match_over <= 1'b0;
      winner     <= 1'b0;
      pause_cnt  <= '0;
    end else begin
      ball_load  <= ball_load_d;
      ball_run   <= ball_run_d;
      serve_side <= serve_side_d;
      score_p1   <= score_p1_d;
      score_p2   <= score_p2_d;
      disp_value <= disp_value_d;
      match_over <= match_over_d;
      winner     <= winner_d;
      pause_cnt  <= pause_cnt_d;
    end
  end

endmodule
